// File: rtl/truth_table_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | truth_table_sequencer: sweeps a small combinational function through all |
// | input vectors, captures its truth table and compares it against EXP.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module truth_table_sequencer #(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXP    = 4'b1101
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 dut_s_i,
  output logic [N_IN-1:0]      dut_in_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2**N_IN-1:0]   table_out_o,
  output logic [N_IN:0]        err_count_o,
  output logic [N_IN-1:0]      first_err_idx_o,
  output logic                 pass_o
);

  localparam int                NV       = 2**N_IN;
  localparam int                EW       = N_IN + 1;
  localparam int                CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]     CNT_INIT = CW'(SETTLE);
  localparam logic [N_IN-1:0]   LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NV-1:0]      tab_q, tab_d;
  logic [EW-1:0]      err_q, err_d;
  logic [N_IN-1:0]    ferr_q, ferr_d;
  logic               pass_q, pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tab_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tab_q   <= tab_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tab_d   = tab_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = CNT_INIT;
          tab_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          tab_d[idx_q] = dut_s_i;
          if (dut_s_i != EXP[idx_q]) begin
            err_d = err_q + EW'(1);
            if (err_q == '0) ferr_d = idx_q;
          end
          // idx stays on the last vector so dut_in holds it after done
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + N_IN'(1);
            cnt_d = CNT_INIT;
          end
        end
      end
      S_DONE: begin
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_in_o        = idx_q;
  assign busy_o          = (state_q == S_WAIT);
  assign done_o          = (state_q == S_DONE);
  assign table_out_o     = tab_q;
  assign err_count_o     = err_q;
  assign first_err_idx_o = ferr_q;
  assign pass_o          = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// Bench for truth_table_sequencer: table-driven sweeps on a 2-input and a
// 3-input instance, plus hand-written abort and mid-sweep reset sequences.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic [1:0] fsel;
  logic       use_b;

  logic       dut_s_a, dut_s_b;
  logic [1:0] dut_in_a;
  logic       busy_a, done_a, pass_a;
  logic [3:0] tab_a;
  logic [2:0] err_a;
  logic [1:0] first_a;

  logic [2:0] dut_in_b;
  logic       busy_b, done_b, pass_b;
  logic [7:0] tab_b;
  logic [3:0] err_b;
  logic [2:0] first_b;

  truth_table_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .dut_s_i(dut_s_a), .dut_in_o(dut_in_a), .busy_o(busy_a), .done_o(done_a),
    .table_out_o(tab_a), .err_count_o(err_a), .first_err_idx_o(first_a),
    .pass_o(pass_a)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(0), .EXP(8'h96)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .dut_s_i(dut_s_b), .dut_in_o(dut_in_b), .busy_o(busy_b), .done_o(done_b),
    .table_out_o(tab_b), .err_count_o(err_b), .first_err_idx_o(first_b),
    .pass_o(pass_b)
  );

  // dut_in = {a,b} for the 2-input function under control
  always_comb begin
    case (fsel)
      2'd0:    dut_s_a = dut_in_a[1] | ~dut_in_a[0];
      2'd1:    dut_s_a = dut_in_a[1] & dut_in_a[0];
      2'd2:    dut_s_a = 1'b1;
      default: dut_s_a = ~(dut_in_a[1] ^ dut_in_a[0]);
    endcase
  end
  assign dut_s_b = ^dut_in_b;

  logic [2:0] m_din;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_tab;
  logic [3:0] m_err;
  logic [2:0] m_first;
  assign m_din   = use_b ? dut_in_b : {1'b0, dut_in_a};
  assign m_busy  = use_b ? busy_b : busy_a;
  assign m_done  = use_b ? done_b : done_a;
  assign m_pass  = use_b ? pass_b : pass_a;
  assign m_tab   = use_b ? tab_b : {4'b0, tab_a};
  assign m_err   = use_b ? err_b : {1'b0, err_a};
  assign m_first = use_b ? first_b : {1'b0, first_a};

  typedef struct {
    bit         use_b;
    bit         hold;
    logic [1:0] fsel;
    logic [7:0] tab;
    logic [3:0] err;
    logic [2:0] first;
    bit         pass;
  } vec_t;

  vec_t vecs [6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input vec_t v);
    int s, nv, dc;
    use_b = v.use_b;
    fsel  = v.fsel;
    s     = v.use_b ? 0 : 1;
    nv    = v.use_b ? 8 : 4;
    dc    = nv * (s + 1) + 1;
    if (v.use_b) start_b = 1'b1;
    else         start_a = 1'b1;
    for (int k = 1; k <= dc + 1; k++) begin
      step();
      if (!v.hold || k == dc + 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (k < dc) begin
        chk("dut_in", 32'(m_din), 32'((k - 1) / (s + 1)));
        chk("busy_run", 32'(m_busy), 32'd1);
        chk("done_early", 32'(m_done), 32'd0);
      end else if (k == dc) begin
        chk("done_pulse", 32'(m_done), 32'd1);
        chk("busy_at_done", 32'(m_busy), 32'd0);
        chk("table_out", 32'(m_tab), 32'(v.tab));
        chk("err_count", 32'(m_err), 32'(v.err));
        chk("first_err", 32'(m_first), 32'(v.first));
      end else begin
        chk("done_after", 32'(m_done), 32'd0);
        chk("busy_after", 32'(m_busy), 32'd0);
        chk("pass", 32'(m_pass), 32'(v.pass));
        chk("dut_in_hold", 32'(m_din), 32'(nv - 1));
      end
    end
  endtask

  initial begin
    bit saw_done;
    vecs[0] = '{1'b0, 1'b0, 2'd0, 8'h0D, 4'd0, 3'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 2'd1, 8'h08, 4'd2, 3'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 8'h0F, 4'd1, 3'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'd3, 8'h09, 4'd1, 3'd2, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 2'd0, 8'h0D, 4'd0, 3'd0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 2'd0, 8'h96, 4'd0, 3'd0, 1'b1};

    rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    fsel = 2'd0; use_b = 1'b0;
    #2;
    chk("rst_a_outputs", {dut_in_a, busy_a, done_a, tab_a, err_a, first_a, pass_a}, 32'd0);
    chk("rst_b_outputs", {dut_in_b, busy_b, done_b, tab_b, err_b, first_b, pass_b}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      sweep(vecs[i]);
      step();
    end

    // abort while vector 2 is driven
    use_b = 1'b0; fsel = 2'd0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step(); step(); step();
    chk("abort_pre_din", 32'(dut_in_a), 32'd2);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_table", 32'(tab_a), 32'h1);
    chk("abort_pass", 32'(pass_a), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done_a) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // asynchronous reset mid-sweep
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step();
    chk("rst_mid_din", 32'(dut_in_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {dut_in_a, busy_a, done_a, tab_a, err_a, first_a, pass_a}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    sweep(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
